// File: rtl/input_cond_pkg.sv
// Shared constants for the input conditioner: debounce FSM state encodings,
// the default debounce length and a helper that sizes the stability counter.
package input_cond_pkg;

  // Debounce FSM encodings. Bit 0 tracks the level currently being accepted;
  // the two IDLE states have both bits equal.
  localparam logic [1:0] IDLE_LO = 2'b00;
  localparam logic [1:0] WAIT_HI = 2'b01;
  localparam logic [1:0] IDLE_HI = 2'b11;
  localparam logic [1:0] WAIT_LO = 2'b10;

  // 20 ms of stable input at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Stability counter width. The counter only has to reach DEBOUNCE_CYCLES-1.
  // The width is kept at least one bit so that a degenerate parameter still
  // elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input bit. It contains a two-flop synchroniser, a four-state
// debounce FSM with a stability counter, and registered level, pulse and
// toggle outputs. The input is expected to be already polarity-normalised,
// so 1 means asserted.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic din_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;

  // Two-flop synchroniser for the asynchronous button/switch line.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM. Any disagreeing sample during a WAIT state drops the FSM
  // back to the previous IDLE state. The counter restarts from zero on every
  // entry to a WAIT state and stops at CNT_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q)                 state_d = IDLE_LO;
        else if (cnt_q == CNT_LAST) state_d = IDLE_HI;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      IDLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s2_q)                  state_d = IDLE_HI;
        else if (cnt_q == CNT_LAST) state_d = IDLE_LO;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-state values are derived from the FSM transition. This lets
  // the registered outputs change on the same edge as the state.
  always_comb begin
    level_d   = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    press_d   = (state_q == WAIT_HI) && (state_d == IDLE_HI);
    release_d = (state_q == WAIT_LO) && (state_d == IDLE_LO);
    toggle_d  = toggle_q ^ press_d;
  end

  // FSM, counter and output registers.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: rtl/input_conditioner.sv
// Front end for the raw KEY/SW lines. It normalises each line's polarity so
// that 1 means asserted, then hands each bit to its own independent
// debounce channel.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            Clk,
  input  logic            Resetn,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggle_out
);

  logic [N_CH-1:0] norm_in;

  // Polarity normalisation happens ahead of the synchronisers.
  assign norm_in = raw_in ^ {N_CH{ACTIVE_LOW}};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .Clk      (Clk),
      .Resetn   (Resetn),
      .din_i    (norm_in[gi]),
      .level_o  (level_out[gi]),
      .press_o  (press_pulse[gi]),
      .release_o(release_pulse[gi]),
      .toggle_o (toggle_out[gi])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4. Instance A is
// active-low (KEY) and instance B is active-high (SW). Each debounced
// press/release that the stimulus should produce is queued with the cycle on
// which its pulse must be visible, and every cycle all outputs are compared
// with the expectation rebuilt from that queue.
module tb_input_conditioner;

  localparam int DC  = 4;
  localparam int NCH = 4;
  // When raw changes at negedge M, the pulse is visible at negedge M+DC+3.
  localparam int LAT = DC + 3;

  typedef struct {
    int cyc;
    int dut;
    int ch;
    bit rel;
  } ev_t;

  logic clk;
  logic rst_n;
  logic [NCH-1:0] raw_a, raw_b;
  logic [NCH-1:0] lvl_a, prs_a, rel_a, tog_a;
  logic [NCH-1:0] lvl_b, prs_b, rel_b, tog_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  ev_t evq[$];
  logic [NCH-1:0] exp_lvl[2];
  logic [NCH-1:0] exp_tog[2];
  logic [NCH-1:0] exp_prs[2];
  logic [NCH-1:0] exp_rel[2];

  input_conditioner #(.N_CH(NCH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_a (
    .Clk(clk), .Resetn(rst_n), .raw_in(raw_a),
    .level_out(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a), .toggle_out(tog_a)
  );

  input_conditioner #(.N_CH(NCH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut_b (
    .Clk(clk), .Resetn(rst_n), .raw_in(raw_b),
    .level_out(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b), .toggle_out(tog_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int d, input logic [NCH-1:0] obs,
                     input logic [NCH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input int d, input int ch, input bit rel);
    ev_t e;
    e.cyc = c;
    e.dut = d;
    e.ch  = ch;
    e.rel = rel;
    evq.push_back(e);
  endtask

  // Advance n cycles. At each negedge, apply the events that are due and
  // compare every output of both instances.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      ev_t keep[$];
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        exp_prs[d] = '0;
        exp_rel[d] = '0;
      end
      if (!rst_n) begin
        evq.delete();
        for (int d = 0; d < 2; d++) begin
          exp_lvl[d] = '0;
          exp_tog[d] = '0;
        end
      end else begin
        foreach (evq[i]) begin
          if (evq[i].cyc == cyc) begin
            if (evq[i].rel) begin
              exp_rel[evq[i].dut][evq[i].ch] = 1'b1;
              exp_lvl[evq[i].dut][evq[i].ch] = 1'b0;
            end else begin
              exp_prs[evq[i].dut][evq[i].ch] = 1'b1;
              exp_lvl[evq[i].dut][evq[i].ch] = 1'b1;
              exp_tog[evq[i].dut][evq[i].ch] = ~exp_tog[evq[i].dut][evq[i].ch];
            end
          end else begin
            keep.push_back(evq[i]);
          end
        end
        evq = keep;
      end
      cmp("level",   0, lvl_a, exp_lvl[0]);
      cmp("press",   0, prs_a, exp_prs[0]);
      cmp("release", 0, rel_a, exp_rel[0]);
      cmp("toggle",  0, tog_a, exp_tog[0]);
      cmp("level",   1, lvl_b, exp_lvl[1]);
      cmp("press",   1, prs_b, exp_prs[1]);
      cmp("release", 1, rel_b, exp_rel[1]);
      cmp("toggle",  1, tog_b, exp_tog[1]);
      $display("cyc=%0d raw_a=%b lvl_a=%b prs_a=%b rel_a=%b tog_a=%b raw_b=%b lvl_b=%b prs_b=%b rel_b=%b tog_b=%b",
               cyc, raw_a, lvl_a, prs_a, rel_a, tog_a, raw_b, lvl_b, prs_b, rel_b, tog_b);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw_a = '1;
    raw_b = '0;
    for (int d = 0; d < 2; d++) begin
      exp_lvl[d] = '0;
      exp_tog[d] = '0;
      exp_prs[d] = '0;
      exp_rel[d] = '0;
    end

    // Reset state.
    step(3);
    rst_n = 1'b1;
    step(3);

    // Clean press on channel 0.
    raw_a[0] = 1'b0;
    push_ev(cyc + LAT, 0, 0, 1'b0);
    step(12);

    // Bounce on channel 1: a 3-cycle glitch, 1 cycle high, then held low.
    raw_a[1] = 1'b0;
    step(3);
    raw_a[1] = 1'b1;
    step(1);
    raw_a[1] = 1'b0;
    push_ev(cyc + LAT, 0, 1, 1'b0);
    step(12);

    // Channel 2: press, release, press, release.
    for (int r = 0; r < 2; r++) begin
      raw_a[2] = 1'b0;
      push_ev(cyc + LAT, 0, 2, 1'b0);
      step(10);
      raw_a[2] = 1'b1;
      push_ev(cyc + LAT, 0, 2, 1'b1);
      step(10);
    end

    // Active-high instance: raw 0->1 on channel 0.
    raw_b[0] = 1'b1;
    push_ev(cyc + LAT, 1, 0, 1'b0);
    step(12);

    // Release everything that is still held.
    raw_a = '1;
    raw_b = '0;
    push_ev(cyc + LAT, 0, 0, 1'b1);
    push_ev(cyc + LAT, 0, 1, 1'b1);
    push_ev(cyc + LAT, 1, 0, 1'b1);
    step(12);

    // All four channels pressed on the same cycle.
    raw_a = '0;
    for (int ch = 0; ch < NCH; ch++) push_ev(cyc + LAT, 0, ch, 1'b0);
    step(12);
    raw_a = '1;
    for (int ch = 0; ch < NCH; ch++) push_ev(cyc + LAT, 0, ch, 1'b1);
    step(12);

    // Reset in the middle of a debounce on channel 3.
    raw_a[3] = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    cmp("rst_async_level",   0, lvl_a, '0);
    cmp("rst_async_press",   0, prs_a, '0);
    cmp("rst_async_release", 0, rel_a, '0);
    cmp("rst_async_toggle",  0, tog_a, '0);
    step(2);
    rst_n = 1'b1;
    push_ev(cyc + LAT, 0, 3, 1'b0);
    step(12);

    // Every queued event must have been consumed.
    total++;
    assert (evq.size() == 0) else begin
      bad++;
      $error("FAIL pending_events observed=%0d expected=0", evq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
